// File: rtl/psk_frame_ctrl.sv
// Framed BPSK symbol sequencer: preamble, fetched payload bytes and a guard interval,
// with the DDS phase accumulator that addresses the sine ROM.
module psk_frame_ctrl #(
  parameter int unsigned SYM_DIV    = 16,
  parameter int unsigned PRE_BITS   = 8,
  parameter logic [7:0]  PRE_PAT    = 8'hAA,
  parameter int unsigned GUARD_SYMS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] n_bytes,
  input  logic [7:0] step,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic [7:0] addr,
  output logic       phase,
  output logic       sym_stb,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPre   = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StGuard = 2'd3;

  // Preamble left-aligned so symbol k always reads bit 7-k.
  localparam logic [7:0] PreAligned = 8'(PRE_PAT << (8 - PRE_BITS));
  localparam logic [7:0] SymLast    = 8'(SYM_DIV - 1);
  localparam logic [3:0] PreLast    = 4'(PRE_BITS - 1);
  localparam logic [3:0] GuardLast  = 4'(GUARD_SYMS - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] sym_cnt_q, sym_cnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] addr_q, addr_d;
  logic       phase_q, phase_d;
  logic       done_q, done_d;
  logic       underrun_q, underrun_d;
  logic [3:0] n_q, n_d;
  logic [7:0] step_q, step_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] acc_cnt_q, acc_cnt_d;
  logic [3:0] sent_cnt_q, sent_cnt_d;
  logic       load_byte;
  logic       xfer;

  assign busy       = (state_q != StIdle);
  assign sym_stb    = busy && (sym_cnt_q == SymLast);
  assign byte_ready = busy && !hold_full_q && (acc_cnt_q < n_q);
  assign xfer       = byte_valid && byte_ready;
  assign addr       = addr_q;
  assign phase      = phase_q;
  assign done       = done_q;
  assign underrun   = underrun_q;

  always_comb begin
    state_d     = state_q;
    sym_cnt_d   = sym_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    done_d      = 1'b0;
    underrun_d  = underrun_q;
    n_d         = n_q;
    step_d      = step_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    acc_cnt_d   = acc_cnt_q;
    sent_cnt_d  = sent_cnt_q;
    load_byte   = 1'b0;

    if (xfer) begin
      hold_d      = byte_data;
      hold_full_d = 1'b1;
      acc_cnt_d   = acc_cnt_q + 4'd1;
    end

    if (state_q == StIdle) begin
      addr_d    = 8'h00;
      phase_d   = 1'b0;
      sym_cnt_d = 8'h00;
      bit_cnt_d = 4'd0;
      if (start) begin
        n_d         = n_bytes;
        step_d      = step;
        underrun_d  = 1'b0;
        hold_full_d = 1'b0;
        acc_cnt_d   = 4'd0;
        sent_cnt_d  = 4'd0;
        phase_d     = PreAligned[7];
        state_d     = StPre;
      end
    end else begin
      sym_cnt_d = sym_stb ? 8'h00 : sym_cnt_q + 8'd1;
      addr_d    = addr_q + step_q + 8'd1;
      if (sym_stb) begin
        unique case (state_q)
          StPre: begin
            if (bit_cnt_q == PreLast) begin
              bit_cnt_d = 4'd0;
              if (n_q == 4'd0) begin
                state_d = StGuard;
                phase_d = 1'b0;
              end else begin
                state_d   = StData;
                load_byte = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              phase_d   = PreAligned[3'd6 - bit_cnt_q[2:0]];
            end
          end
          StData: begin
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (sent_cnt_q == n_q) begin
                state_d = StGuard;
                phase_d = 1'b0;
              end else begin
                load_byte = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              shift_d   = {shift_q[6:0], 1'b0};
              phase_d   = shift_q[6];
            end
          end
          StGuard: begin
            if (bit_cnt_q == GuardLast) begin
              state_d   = StIdle;
              done_d    = 1'b1;
              addr_d    = 8'h00;
              bit_cnt_d = 4'd0;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end

    // A missing byte at a boundary goes out as zeros but still uses up a payload slot.
    if (load_byte) begin
      sent_cnt_d = sent_cnt_q + 4'd1;
      if (hold_full_q) begin
        shift_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        shift_d    = 8'h00;
        underrun_d = 1'b1;
      end
      phase_d = shift_d[7];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sym_cnt_q   <= 8'h00;
      bit_cnt_q   <= 4'd0;
      addr_q      <= 8'h00;
      phase_q     <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      n_q         <= 4'd0;
      step_q      <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      acc_cnt_q   <= 4'd0;
      sent_cnt_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      sym_cnt_q   <= sym_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      n_q         <= n_d;
      step_q      <= step_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      acc_cnt_q   <= acc_cnt_d;
      sent_cnt_q  <= sent_cnt_d;
    end
  end

endmodule

// File: doc/psk_frame_ctrl.md
# psk_frame_ctrl

Frame sequencer for the BPSK transmit path. It owns the DDS phase accumulator that addresses the 256-entry sine ROM, and it drives the phase-select bit into the phase inverter. It replaces the free-running m-sequence source with a framed bit stream: fixed preamble, then 0–15 payload bytes fetched over a valid/ready handshake, then a guard interval. One symbol lasts SYM_DIV clocks.

## Interface
- SYM_DIV, 16: clocks per symbol; legal range 2..256.
- PRE_BITS, 8: preamble length in symbols; legal range 1..8.
- PRE_PAT, 8'hAA: preamble pattern, sent MSB-first from bit PRE_BITS-1.
- GUARD_SYMS, 2: phase-0 symbols sent after the payload; legal range 1..15.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- n_bytes  in  4  payload byte count; latched on accepted start.
- step  in  8  DDS step N; latched on accepted start; increment = N+1.
- byte_data  in  8  payload byte.
- byte_valid  in  1  byte_data is valid.
- byte_ready  out  1  block can accept a byte.
- addr  out  8  sine ROM address (phase accumulator).
- phase  out  1  0 = 0°, 1 = 180°; feeds the inverter select.
- sym_stb  out  1  high on the last clock of every symbol.
- busy  out  1  a frame is in progress.
- done  out  1  one-clock pulse at frame end.
- underrun  out  1  sticky; set when a payload byte was missing; cleared by the next accepted start.

## Operation
- Reset values: addr=0, phase=0, sym_stb=0, busy=0, done=0, byte_ready=0, underrun=0, state IDLE. Reset mid-frame aborts the frame immediately; no done pulse.
- States: IDLE → PRE → DATA → GUARD → IDLE. If latched n_bytes=0, PRE goes directly to GUARD.
- IDLE
  - addr is held at 0 and phase=0.
  - start=1 latches n_bytes and step, clears underrun, zeroes the symbol timer and bit index, and enters PRE.
- Symbol timer
  - sym_cnt counts 0..SYM_DIV-1 while busy.
  - sym_stb = busy && sym_cnt==SYM_DIV-1.
  - State, bit index and phase advance only at sym_stb.
- Accumulator
  - While busy: addr <= addr + step + 1, mod 256.
  - step=255 gives an increment of 0, so addr stays frozen. This is legal.
- PRE: phase = PRE_PAT[PRE_BITS-1-k] for preamble symbol k.
- Byte fetch
  - One-byte holding register.
  - byte_ready = busy && hold empty && accepted count < n_bytes.
  - A transfer occurs on a clock where byte_valid && byte_ready. Fetching starts as soon as PRE is entered.
- DATA
  - At each byte boundary (the sym_stb ending the preamble or ending bit 0 of the previous byte), the holding register moves into the shift register.
  - Bits go out MSB-first: phase = shift[7].
  - If the holding register is empty at a boundary: set underrun, transmit 8'h00, and count that byte as sent. A byte arriving late counts toward n_bytes and is sent at the next boundary.
- GUARD: phase=0 for GUARD_SYMS symbols. The final sym_stb sends the block to IDLE; done=1 and busy=0 in the next clock.
- start while busy is ignored. byte_valid while byte_ready=0 is ignored.

## Timing
- Symbol and frame lengths
  - Accepted start at edge t: busy=1 from t+1.
  - Symbol 0 phase is valid from t+1 and lasts exactly SYM_DIV clocks.
  - Frame length L = (PRE_BITS + 8·n_bytes + GUARD_SYMS)·SYM_DIV clocks.
  - busy stays high for exactly L clocks, and done pulses on clock t+L+1.
- Phase transitions
  - phase changes only on the clock after sym_stb.
  - phase is registered, with no combinational path from byte_data.
- The sine ROM has a 1-clock read latency. Symbol edges at the inverter therefore lead the sine sample by one clock; this is accepted.
- Back-to-back frames: start asserted in the done cycle is accepted, since the block is already in IDLE. The gap between frames is 1 clock.
- byte_ready may stay high across clocks; it drops on the clock after a transfer.

## Test plan
- Preamble only: SYM_DIV=4, n_bytes=0, step=0 → phase sequence 1,0,1,0,1,0,1,0,0,0 (4 clocks each); busy for 40 clocks; addr 1,2,3…; done once.
- One byte 0xC5 pre-loaded, n_bytes=1 → after the preamble, phase 1,1,0,0,0,1,0,1; byte_ready drops after the single transfer; underrun=0.
- Three bytes with byte_valid withheld for the second until after its boundary → second byte sent as 0x00, underrun=1, late byte sent third, frame length unchanged.
- step=255 → addr stays 0 through the whole frame; step=63 → addr steps by 64, wrapping 192→0.
- rst_n pulsed low mid-DATA → all outputs at reset values immediately; no done pulse; the next start runs a clean frame.
- start held high during a frame and in the done cycle → second frame starts at done+1; no restart during the first frame.
